uart_wb_bridge: RTL and testbench

- Serial debug bridge inside `soc_template`, placed between the UART byte receiver/transmitter and the system Wishbone bus.
- Decodes framed command bytes arriving from the host-side UART into single 32-bit Wishbone master read/write cycles.
- Returns status or read data as a byte stream to the UART transmitter.
- Lets the testbench UART model (and a lab host) peek and poke SoC registers without firmware.

---
 rtl/uart_wb_bridge.sv | 166 ++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_bridge.sv
// UART byte stream to single-beat 32-bit Wishbone master bridge.
// Build option: define UART_WB_BRIDGE_TIMEOUT_EN to add a bus watchdog of TIMEOUT cycles.
//
// state | meaning
// IDLE  | waiting for a command byte ('W' or 'R'), others dropped
// ADDR  | collecting 4 address bytes, MSB first
// DATA  | collecting 4 write-data bytes, MSB first
// BUS   | Wishbone cycle outstanding
// RESP  | sending ACK/NAK or 4 read-data bytes
module uart_wb_bridge #(
  parameter int TIMEOUT = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state;
  logic        we;
  logic        err;
  logic [1:0]  byte_cnt;
  logic [31:0] rdata;
  logic        rx_fire;
  logic        tx_fire;
  logic        timeout_hit;
  logic        bus_err;
  logic        bus_done;

  assign rx_fire  = rx_valid_i & rx_ready_o;
  assign tx_fire  = tx_valid_o & tx_ready_i;
  assign wb_sel_o = 4'hF;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  logic [15:0] timer;
  assign timeout_hit = (timer == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // err wins over a simultaneous ack
  assign bus_err  = wb_err_i | timeout_hit;
  assign bus_done = wb_ack_i | bus_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      we         <= 1'b0;
      err        <= 1'b0;
      byte_cnt   <= 2'd0;
      rdata      <= 32'h0;
      rx_ready_o <= 1'b0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
      wb_adr_o   <= 32'h0;
      wb_dat_o   <= 32'h0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      busy_o     <= 1'b0;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
      timer      <= 16'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rx_ready_o <= 1'b1;
          if (rx_fire && (rx_data_i == 8'h57 || rx_data_i == 8'h52)) begin
            we       <= (rx_data_i == 8'h57);
            byte_cnt <= 2'd0;
            busy_o   <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: if (rx_fire) begin
          wb_adr_o <= {wb_adr_o[23:0], rx_data_i};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (we) begin
              state <= DATA;
            end else begin
              rx_ready_o <= 1'b0;
              wb_cyc_o   <= 1'b1;
              wb_stb_o   <= 1'b1;
              wb_we_o    <= 1'b0;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
              timer      <= 16'h0;
`endif
              state      <= BUS;
            end
          end
        end
        DATA: if (rx_fire) begin
          wb_dat_o <= {wb_dat_o[23:0], rx_data_i};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            rx_ready_o <= 1'b0;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            wb_we_o    <= 1'b1;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
            timer      <= 16'h0;
`endif
            state      <= BUS;
          end
        end
        BUS: begin
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
          timer <= timer + 16'd1;
`endif
          if (bus_done) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            err        <= bus_err;
            byte_cnt   <= 2'd0;
            tx_valid_o <= 1'b1;
            state      <= RESP;
            if (bus_err) begin
              tx_data_o <= 8'h15;
            end else if (we) begin
              tx_data_o <= 8'h06;
            end else begin
              tx_data_o <= wb_dat_i[31:24];
              rdata     <= {wb_dat_i[23:0], 8'h00};
            end
          end
        end
        RESP: if (tx_fire) begin
          if (err || we || byte_cnt == 2'd3) begin
            tx_valid_o <= 1'b0;
            rx_ready_o <= 1'b1;
            busy_o     <= 1'b0;
            err        <= 1'b0;
            state      <= IDLE;
          end else begin
            // read data drains from the top of the shift register
            tx_data_o <= rdata[31:24];
            rdata     <= {rdata[23:0], 8'h00};
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: frames in over rx, Wishbone slave model, tx bytes out.
module tb_uart_wb_bridge;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } wb_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic        s_ack;
  logic        s_err;
  logic        busy_o;

  int          checks = 0;
  int          errors = 0;
  bit          to_flag;
  int          slave_mode;     // 0 ack, 1 err, 2 err+ack, 3 never answer
  int          slave_delay;
  int          s_cnt;
  logic [31:0] slave_rdata;
  bit          data_from_adr;
  logic        cyc_prev;
  int          cyc_len;
  int          last_len;
  bit          stab_err = 1'b0;
  wb_t         cur_wb;

  logic [7:0] exp_tx[$];
  logic [7:0] obs_tx[$];
  wb_t        exp_wb[$];
  wb_t        obs_wb[$];

  always #5 wb_clk_i = ~wb_clk_i;

  uart_wb_bridge #(.TIMEOUT(8)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_o  (wb_sel_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_ack_i  (s_ack),
    .wb_err_i  (s_err),
    .busy_o    (busy_o)
  );

  assign wb_dat_i = data_from_adr ? (wb_adr_o ^ 32'h5A5A_A5A5) : slave_rdata;

  // registered slave: answers slave_delay cycles after it first sees the strobe
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_cnt <= 0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !s_ack && !s_err) begin
        if (s_cnt >= slave_delay && slave_mode != 3) begin
          s_ack <= (slave_mode != 1);
          s_err <= (slave_mode != 0);
          s_cnt <= 0;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else if (!wb_cyc_o) begin
        s_cnt <= 0;
      end
    end
  end

  // monitors: accepted tx bytes, bus cycles, cycle length, attribute stability
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_prev <= 1'b0;
      cyc_len  <= 0;
    end else begin
      cyc_prev <= wb_cyc_o;
      if (tx_valid_o && tx_ready_i) obs_tx.push_back(tx_data_o);
      if (wb_cyc_o && !cyc_prev) begin
        obs_wb.push_back({wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o});
        cur_wb  <= {wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o};
        cyc_len <= 1;
      end else if (wb_cyc_o) begin
        cyc_len <= cyc_len + 1;
        if ({wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o} !== {cur_wb.adr, cur_wb.dat, cur_wb.we, 1'b1})
          stab_err <= 1'b1;
      end
      if (!wb_cyc_o && cyc_prev) last_len <= cyc_len;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 200) to_flag = 1'b1;
    @(posedge wb_clk_i);
    #1 rx_valid_i = 1'b0;
  endtask

  // d is the write data, or for a read the data the slave is expected to return
  task automatic send_frame(input bit w, input logic [31:0] a, input logic [31:0] d, input bit nak);
    exp_wb.push_back({a, d, w, 4'hF});
    if (nak) exp_tx.push_back(8'h15);
    else if (w) exp_tx.push_back(8'h06);
    else for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
    send_byte(w ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (w) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge wb_clk_i);
    while ((busy_o || tx_valid_o) && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= budget) to_flag = 1'b1;
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b1;
    slave_mode = 0; slave_delay = 0; slave_rdata = 32'h0; data_from_adr = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, tx_valid_o, rx_ready_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got cyc,stb,we,txv,rxr,busy=%b want 000000",
               {wb_cyc_o, wb_stb_o, wb_we_o, tx_valid_o, rx_ready_o, busy_o});
    end
    checks++;
    if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || tx_data_o !== 8'h00 || wb_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_data got adr=%h dat=%h tx=%h sel=%h want 0 0 0 f", wb_adr_o, wb_dat_o, tx_data_o, wb_sel_o);
    end
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (rx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rx_ready=%b busy=%b want 1 0", rx_ready_o, busy_o);
    end
  endtask

  task automatic test_write;
    wb_t e, o;
    logic [7:0] et, ot;
    int n;
    to_flag = 1'b0; slave_mode = 0; slave_delay = 1;
    send_frame(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    wait_idle(100);
    // minimum latency: consuming edge counts as 1, registered slave acks on the next
    slave_delay = 0;
    send_frame(1'b1, 32'h0000_1008, 32'h0102_0304, 1'b0);
    n = 1;
    while (!tx_valid_o && n < 20) begin
      @(posedge wb_clk_i);
      #1 n++;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL write_latency got %0d edges want 3", n); end
    wait_idle(100);
    checks++;
    if (to_flag) begin errors++; $display("FAIL write_stall got timeout=1 want 0"); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front(); checks++;
      if (obs_wb.size() == 0) begin errors++; $display("FAIL write_wb missing want adr=%h", e.adr); end
      else begin
        o = obs_wb.pop_front();
        if (o.adr !== e.adr || o.dat !== e.dat || o.we !== e.we || o.sel !== 4'hF) begin
          errors++;
          $display("FAIL write_wb got adr=%h dat=%h we=%b sel=%h want adr=%h dat=%h we=%b sel=f",
                   o.adr, o.dat, o.we, o.sel, e.adr, e.dat, e.we);
        end
      end
    end
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front(); checks++;
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      if (ot !== et) begin errors++; $display("FAIL write_tx got %h want %h", ot, et); end
    end
    checks++;
    if (obs_tx.size() != 0 || obs_wb.size() != 0 || stab_err) begin
      errors++;
      $display("FAIL write_extra got tx=%0d wb=%0d unstable=%b want 0 0 0", obs_tx.size(), obs_wb.size(), stab_err);
    end
  endtask

  task automatic test_read;
    wb_t e, o;
    logic [7:0] et, ot;
    to_flag = 1'b0; slave_mode = 0; slave_delay = 1; slave_rdata = 32'h1234_5678;
    send_frame(1'b0, 32'h0000_1004, 32'h1234_5678, 1'b0);
    wait_idle(100);
    checks++;
    if (to_flag) begin errors++; $display("FAIL read_stall got timeout=1 want 0"); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front(); checks++;
      if (obs_wb.size() == 0) begin errors++; $display("FAIL read_wb missing want adr=%h", e.adr); end
      else begin
        o = obs_wb.pop_front();
        if (o.adr !== e.adr || o.we !== 1'b0 || o.sel !== 4'hF) begin
          errors++;
          $display("FAIL read_wb got adr=%h we=%b sel=%h want adr=%h we=0 sel=f", o.adr, o.we, o.sel, e.adr);
        end
      end
    end
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front(); checks++;
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      if (ot !== et) begin errors++; $display("FAIL read_tx got %h want %h", ot, et); end
    end
    checks++;
    if (obs_tx.size() != 0) begin errors++; $display("FAIL read_extra got %0d extra bytes want 0", obs_tx.size()); end
  endtask

  task automatic test_error;
    logic [7:0] et, ot;
    to_flag = 1'b0; slave_delay = 0; slave_rdata = 32'hFFFF_FFFF;
    slave_mode = 1;
    send_frame(1'b0, 32'h0000_0100, 32'h0, 1'b1);
    wait_idle(100);
    slave_mode = 2;
    send_frame(1'b0, 32'h0000_0104, 32'h0, 1'b1);
    wait_idle(100);
    slave_mode = 1;
    send_frame(1'b1, 32'h0000_0108, 32'h5555_AAAA, 1'b1);
    wait_idle(100);
    slave_mode = 0;
    checks++;
    if (to_flag) begin errors++; $display("FAIL error_stall got timeout=1 want 0"); end
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front(); checks++;
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      if (ot !== et) begin errors++; $display("FAIL error_tx got %h want %h", ot, et); end
    end
    checks++;
    if (obs_tx.size() != 0 || obs_wb.size() != 3) begin
      errors++;
      $display("FAIL error_extra got tx=%0d wb=%0d want 0 3", obs_tx.size(), obs_wb.size());
    end
    exp_wb.delete(); obs_wb.delete();
  endtask

  task automatic test_garbage_backpressure;
    logic [7:0] et, ot, hold;
    bit stable;
    int n;
    to_flag = 1'b0; slave_mode = 0; slave_delay = 2; slave_rdata = 32'hA5C3_0F81;
    send_byte(8'hAA);
    send_byte(8'h00);
    @(negedge wb_clk_i);
    checks++;
    if (busy_o !== 1'b0 || tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1 || obs_wb.size() != 0) begin
      errors++;
      $display("FAIL garbage_idle got busy=%b txv=%b rxr=%b wb=%0d want 0 0 1 0", busy_o, tx_valid_o, rx_ready_o, obs_wb.size());
    end
    tx_ready_i = 1'b0;
    send_frame(1'b0, 32'h0000_0020, 32'hA5C3_0F81, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!tx_valid_o && n < 100) begin
        @(negedge wb_clk_i);
        n++;
      end
      hold = tx_data_o;
      stable = 1'b1;
      repeat (20) begin
        @(negedge wb_clk_i);
        if (tx_data_o !== hold || tx_valid_o !== 1'b1) stable = 1'b0;
      end
      checks++;
      if (!stable) begin errors++; $display("FAIL bp_hold byte %0d got txd=%h txv=%b want held %h", k, tx_data_o, tx_valid_o, hold); end
      tx_ready_i = 1'b1;
      @(negedge wb_clk_i);
      tx_ready_i = 1'b0;
    end
    tx_ready_i = 1'b1;
    wait_idle(100);
    checks++;
    if (to_flag) begin errors++; $display("FAIL bp_stall got timeout=1 want 0"); end
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front(); checks++;
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      if (ot !== et) begin errors++; $display("FAIL bp_tx got %h want %h", ot, et); end
    end
    checks++;
    if (obs_tx.size() != 0 || obs_wb.size() != 1) begin
      errors++;
      $display("FAIL bp_extra got tx=%0d wb=%0d want 0 1", obs_tx.size(), obs_wb.size());
    end
    exp_wb.delete(); obs_wb.delete();
  endtask

  task automatic test_timeout;
    logic [7:0] et, ot;
    to_flag = 1'b0; slave_delay = 0; slave_mode = 3; slave_rdata = 32'hCAFE_F00D;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    send_frame(1'b0, 32'h0000_0080, 32'h0, 1'b1);
    wait_idle(100);
    checks++;
    if (last_len !== 8) begin errors++; $display("FAIL timeout_len got %0d cyc cycles want 8", last_len); end
`else
    send_frame(1'b0, 32'h0000_0084, 32'hCAFE_F00D, 1'b0);
    repeat (1000) @(negedge wb_clk_i);
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout got cyc=%b stb=%b after 1000 cycles want 1 1", wb_cyc_o, wb_stb_o);
    end
    slave_mode = 0;
    wait_idle(100);
`endif
    slave_mode = 0;
    checks++;
    if (to_flag) begin errors++; $display("FAIL timeout_stall got timeout=1 want 0"); end
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front(); checks++;
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      if (ot !== et) begin errors++; $display("FAIL timeout_tx got %h want %h", ot, et); end
    end
    checks++;
    if (obs_tx.size() != 0) begin errors++; $display("FAIL timeout_extra got %0d bytes want 0", obs_tx.size()); end
    exp_wb.delete(); obs_wb.delete();
  endtask

  task automatic test_reset_mid;
    wb_t e, o;
    logic [7:0] et, ot;
    int n;
    to_flag = 1'b0; slave_delay = 0;
    // reset while the bus cycle is outstanding
    slave_mode = 3;
    send_frame(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_bus_pre got cyc=%b want 1", wb_cyc_o); end
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, tx_valid_o, busy_o} !== 4'b0) begin
      errors++;
      $display("FAIL rst_bus got cyc,stb,txv,busy=%b want 0000", {wb_cyc_o, wb_stb_o, tx_valid_o, busy_o});
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    slave_mode = 0;
    // reset after two address bytes
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    #2 wb_rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || rx_ready_o !== 1'b0 || wb_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_addr got busy=%b rxr=%b adr=%h want 0 0 0", busy_o, rx_ready_o, wb_adr_o);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    // reset while a response byte is being offered
    slave_rdata = 32'h1122_3344;
    tx_ready_i = 1'b0;
    send_frame(1'b0, 32'h0000_0044, 32'h1122_3344, 1'b0);
    n = 0;
    while (!tx_valid_o && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    #1 wb_rst_i = 1'b1;
    #1;
    checks++;
    if (tx_valid_o !== 1'b0 || n >= 50) begin
      errors++;
      $display("FAIL rst_resp got txv=%b waited=%0d want 0 <50", tx_valid_o, n);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tx_ready_i = 1'b1;
    exp_tx.delete(); obs_tx.delete(); exp_wb.delete(); obs_wb.delete();
    // next full frame runs normally
    to_flag = 1'b0; slave_delay = 1;
    send_frame(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 1'b0);
    wait_idle(100);
    checks++;
    if (to_flag) begin errors++; $display("FAIL rst_after_stall got timeout=1 want 0"); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front(); checks++;
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      if (o.adr !== e.adr || o.dat !== e.dat || o.we !== 1'b1) begin
        errors++;
        $display("FAIL rst_after_wb got adr=%h dat=%h we=%b want adr=%h dat=%h we=1", o.adr, o.dat, o.we, e.adr, e.dat);
      end
    end
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front(); checks++;
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      if (ot !== et) begin errors++; $display("FAIL rst_after_tx got %h want %h", ot, et); end
    end
  endtask

  task automatic test_back_to_back;
    wb_t e, o;
    logic [7:0] et, ot;
    logic [31:0] a, d;
    bit w;
    to_flag = 1'b0; slave_mode = 0; slave_delay = 0; data_from_adr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = (k % 2 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      a = $urandom;
      d = w ? 32'($urandom) : (a ^ 32'h5A5A_A5A5);
      send_frame(w, a, d, 1'b0);
    end
    wait_idle(200);
    data_from_adr = 1'b0;
    checks++;
    if (to_flag) begin errors++; $display("FAIL b2b_stall got timeout=1 want 0"); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front(); checks++;
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      if (o.adr !== e.adr || o.we !== e.we || (e.we && o.dat !== e.dat)) begin
        errors++;
        $display("FAIL b2b_wb got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b", o.adr, o.dat, o.we, e.adr, e.dat, e.we);
      end
    end
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front(); checks++;
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      if (ot !== et) begin errors++; $display("FAIL b2b_tx got %h want %h", ot, et); end
    end
    checks++;
    if (obs_tx.size() != 0 || obs_wb.size() != 0 || stab_err) begin
      errors++;
      $display("FAIL b2b_extra got tx=%0d wb=%0d unstable=%b want 0 0 0", obs_tx.size(), obs_wb.size(), stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_garbage_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish by 500000 want finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
